// File: rtl/pc_ir_datapath_regs.sv
// Architectural state of the multicycle RISC-V datapath: PC, IR, MDR, ALUOut, the memory
// address mux, IR field decode with immediate generation, and a retired-fetch counter.
module pc_ir_datapath_regs #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ir_write_i,
  input  logic                 pc_write_i,
  input  logic                 pc_write_cond_i,
  input  logic                 pc_source_i,
  input  logic                 iord_i,
  input  logic                 zero_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      mem_rdata_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [XLEN-1:0]      mem_addr_o,
  output logic [31:0]          instr_o,
  output logic [6:0]           opcode_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [XLEN-1:0]      mdr_o,
  output logic [XLEN-1:0]      alu_out_o,
  output logic                 pc_misalign_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  localparam int unsigned ILEN      = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [ILEN-1:0]      instr_q, instr_d;
  logic [XLEN-1:0]      mdr_q, mdr_d;
  logic [XLEN-1:0]      alu_out_q, alu_out_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic                 pc_en_c;
  logic [XLEN-1:0]      pc_tgt_c;
  logic signed [31:0]   imm32_c;

  // Unconditional write dominates; conditional write only on a taken branch.
  assign pc_en_c  = pc_write_i | (pc_write_cond_i & zero_i);
  assign pc_tgt_c = pc_source_i ? alu_out_q : alu_result_i;

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    mdr_d      = mem_rdata_i;
    alu_out_d  = alu_result_i;
    misalign_d = 1'b0;
    instret_d  = instret_q;
    if (pc_en_c) begin
      pc_d       = {pc_tgt_c[XLEN-1:2], 2'b00};
      misalign_d = (pc_tgt_c[1:0] != 2'b00);
    end
    if (ir_write_i) begin
      instr_d   = ILEN'(mem_rdata_i);
      instret_d = instret_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      mdr_q      <= '0;
      alu_out_q  <= '0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      mdr_q      <= mdr_d;
      alu_out_q  <= alu_out_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  // Immediate generation; scrambled B/J bit orders are reassembled before sign extension.
  always_comb begin
    imm32_c = '0;
    unique case (instr_q[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm32_c = 32'($signed(instr_q[31:20]));
      OP_STORE:
        imm32_c = 32'($signed({instr_q[31:25], instr_q[11:7]}));
      OP_BRANCH:
        imm32_c = 32'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        imm32_c = {instr_q[31:12], 12'b0};
      OP_JAL:
        imm32_c = 32'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
      default:
        imm32_c = '0;
    endcase
  end

  assign opcode_o = instr_q[6:0];
  assign rd_o     = instr_q[11:7];
  assign funct3_o = instr_q[14:12];
  assign rs1_o    = instr_q[19:15];
  assign rs2_o    = instr_q[24:20];
  assign funct7_o = instr_q[31:25];
  assign imm_o    = XLEN'(imm32_c);

  assign mem_addr_o    = iord_i ? alu_out_q : pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign mdr_o         = mdr_q;
  assign alu_out_o     = alu_out_q;
  assign pc_misalign_o = misalign_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_pc_ir_datapath_regs.sv
// Self-checking bench for pc_ir_datapath_regs: directed scenarios plus randomized control
// against a behavioural model of the architectural state.
module tb_pc_ir_datapath_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_write, pc_write, pc_write_cond, pc_source, iord, zero;
  logic [31:0] alu_result, mem_rdata;
  logic [31:0] pc_o, mem_addr_o, instr_o, imm_o, mdr_o, alu_out_o, instret_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic        pc_misalign_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_ir_datapath_regs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ir_write_i     (ir_write),
    .pc_write_i     (pc_write),
    .pc_write_cond_i(pc_write_cond),
    .pc_source_i    (pc_source),
    .iord_i         (iord),
    .zero_i         (zero),
    .alu_result_i   (alu_result),
    .mem_rdata_i    (mem_rdata),
    .pc_o           (pc_o),
    .mem_addr_o     (mem_addr_o),
    .instr_o        (instr_o),
    .opcode_o       (opcode_o),
    .rd_o           (rd_o),
    .rs1_o          (rs1_o),
    .rs2_o          (rs2_o),
    .funct3_o       (funct3_o),
    .funct7_o       (funct7_o),
    .imm_o          (imm_o),
    .mdr_o          (mdr_o),
    .alu_out_o      (alu_out_o),
    .pc_misalign_o  (pc_misalign_o),
    .instret_o      (instret_o)
  );

  // Behavioural model of the architectural state
  logic [31:0] m_pc, m_instr, m_mdr, m_alu_out, m_instret;
  logic        m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'd0; m_instr <= 32'h13; m_mdr <= 32'd0; m_alu_out <= 32'd0;
      m_instret <= 32'd0; m_mis <= 1'b0;
    end else begin
      m_mdr     <= mem_rdata;
      m_alu_out <= alu_result;
      if (pc_write || (pc_write_cond && zero)) begin
        m_pc  <= ((pc_source ? m_alu_out : alu_result) / 32'd4) * 32'd4;
        m_mis <= ((pc_source ? m_alu_out : alu_result) % 32'd4) != 32'd0;
      end else begin
        m_mis <= 1'b0;
      end
      if (ir_write) begin
        m_instr   <= mem_rdata;
        m_instret <= m_instret + 32'd1;
      end
    end
  end

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    int t;
    t = int'(ins);
    case (ins & 32'h7F)
      32'h03, 32'h13, 32'h67: begin
        t = t >>> 20;
        return 32'(t);
      end
      32'h23: begin
        t = (t >>> 25) * 32;
        return 32'(t) | ((ins >> 7) & 32'd31);
      end
      32'h63: begin
        t = (t >>> 31) * 4096;
        return 32'(t) | (((ins >> 7) & 32'd1) << 11) | (((ins >> 25) & 32'd63) << 5)
               | (((ins >> 8) & 32'd15) << 1);
      end
      32'h37, 32'h17: return ins & 32'hFFFF_F000;
      32'h6F: begin
        t = (t >>> 31) * 1048576;
        return 32'(t) | (((ins >> 12) & 32'd255) << 12) | (((ins >> 20) & 32'd1) << 11)
               | (((ins >> 21) & 32'd1023) << 1);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 8))
      0: op = 7'h03;
      1: op = 7'h13;
      2: op = 7'h67;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h37;
      6: op = 7'h17;
      7: op = 7'h6F;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", pc_o, m_pc);
    chk("instr", instr_o, m_instr);
    chk("mdr", mdr_o, m_mdr);
    chk("alu_out", alu_out_o, m_alu_out);
    chk("misalign", 32'(pc_misalign_o), 32'(m_mis));
    chk("instret", instret_o, m_instret);
    chk("mem_addr", mem_addr_o, iord ? m_alu_out : m_pc);
    chk("opcode", 32'(opcode_o), m_instr & 32'h7F);
    chk("rd", 32'(rd_o), (m_instr >> 7) & 32'd31);
    chk("rs1", 32'(rs1_o), (m_instr >> 15) & 32'd31);
    chk("rs2", 32'(rs2_o), (m_instr >> 20) & 32'd31);
    chk("funct3", 32'(funct3_o), (m_instr >> 12) & 32'd7);
    chk("funct7", 32'(funct7_o), m_instr >> 25);
    chk("imm", imm_o, exp_imm(m_instr));
  endtask

  task automatic set_idle();
    ir_write = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0;
    pc_source = 1'b0; iord = 1'b0; zero = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Async reset asserted mid-cycle, held across one edge, released mid-cycle.
  task automatic reset_pulse(input logic pin_literals);
    #2;
    rst_n = 1'b0;
    #1;
    if (pin_literals) begin
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_instr", instr_o, 32'h0000_0013);
      chk("rst_opcode", 32'(opcode_o), 32'h13);
      chk("rst_imm", imm_o, 32'd0);
      chk("rst_instret", instret_o, 32'd0);
      chk("rst_misalign", 32'(pc_misalign_o), 32'd0);
    end
    compare_all();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    alu_result = 32'd0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("init_pc", pc_o, 32'd0);
    chk("init_instr", instr_o, 32'h0000_0013);
    chk("init_instret", instret_o, 32'd0);

    // Fetch of sw x10,8(x2)
    mem_rdata = 32'h00A1_2423; ir_write = 1'b1; pc_write = 1'b1; alu_result = 32'd4;
    tick();
    chk("f_pc", pc_o, 32'd4);
    chk("f_opcode", 32'(opcode_o), 32'h23);
    chk("f_rs1", 32'(rs1_o), 32'd2);
    chk("f_rs2", 32'(rs2_o), 32'd10);
    chk("f_funct3", 32'(funct3_o), 32'd2);
    chk("f_imm", imm_o, 32'd8);
    chk("f_instret", instret_o, 32'd1);

    // Conditional branch: not taken, then taken from ALUOut
    set_idle(); pc_write_cond = 1'b1; zero = 1'b0; alu_result = 32'h40;
    tick();
    chk("br_nt_pc", pc_o, 32'd4);
    zero = 1'b1; pc_source = 1'b1;
    tick();
    chk("br_t_pc", pc_o, 32'h40);

    // Address mux follows IorD without a clock edge
    set_idle(); alu_result = 32'h100;
    tick();
    iord = 1'b1;
    #1 chk("iord1_addr", mem_addr_o, 32'h100);
    iord = 1'b0;
    #1 chk("iord0_addr", mem_addr_o, 32'h40);
    tick();

    // Misaligned target: PC aligned, flag pulses one cycle
    pc_write = 1'b1; alu_result = 32'h6;
    tick();
    chk("mis_pc", pc_o, 32'h4);
    chk("mis_hi", 32'(pc_misalign_o), 32'd1);
    set_idle();
    tick();
    chk("mis_lo", 32'(pc_misalign_o), 32'd0);

    // Unconditional write wins over a not-taken conditional
    pc_write = 1'b1; pc_write_cond = 1'b1; zero = 1'b0; alu_result = 32'h80;
    tick();
    chk("both_pc", pc_o, 32'h80);

    // lw x1,-4(x2): negative immediate, MDR one cycle behind memory
    set_idle(); mem_rdata = 32'hFFC1_2083; ir_write = 1'b1;
    tick();
    chk("lw_rd", 32'(rd_o), 32'd1);
    chk("lw_imm", imm_o, 32'hFFFF_FFFC);
    ir_write = 1'b0; mem_rdata = 32'h1234_5678;
    #1 chk("mdr_hold", mdr_o, 32'hFFC1_2083);
    tick();
    chk("mdr_next", mdr_o, 32'h1234_5678);

    // Reset mid-fetch
    ir_write = 1'b1; pc_write = 1'b1; alu_result = 32'h200; mem_rdata = 32'h00A1_2423;
    reset_pulse(1'b1);
    set_idle();
    tick();

    for (int i = 0; i < 800; i++) begin
      ir_write      = ($urandom_range(0, 2) == 0);
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 3) == 0);
      zero          = 1'($urandom_range(0, 1));
      pc_source     = 1'($urandom_range(0, 1));
      iord          = 1'($urandom_range(0, 1));
      alu_result    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      mem_rdata     = rand_instr();
      if ($urandom_range(0, 99) == 0) reset_pulse(1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
